// File: rtl/bus_responder.sv
//------------------------------------------------------------------------------
// Module   : bus_responder
// Purpose  : Single bus slave decoding RAM, LED register, synchronised switches
//            and a prescaled timer with wrap flag; one-cycle read latency.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_responder #(
  parameter int DATA_W    = 9,
  parameter int ADDR_W    = 9,
  parameter int RAM_DEPTH = 128,
  parameter int PRESCALE  = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] Dout,
  input  logic              W,
  input  logic [DATA_W-1:0] SW,
  output logic [DATA_W-1:0] Din,
  output logic [DATA_W-1:0] LEDR
);

  localparam int c_RAM_AW = $clog2(RAM_DEPTH);
  localparam int c_PRE_W  = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(PRESCALE - 1);

  logic [DATA_W-1:0]   r_ram [RAM_DEPTH];
  logic [DATA_W-1:0]   r_din;
  logic [DATA_W-1:0]   r_led;
  logic [DATA_W-1:0]   r_sw_meta;
  logic [DATA_W-1:0]   r_sw_sync;
  logic [DATA_W-1:0]   r_count;
  logic [c_PRE_W-1:0]  r_pre;
  logic                r_flag;

  logic [1:0]          w_region;
  logic [c_RAM_AW-1:0] w_ram_idx;
  logic                w_wr_ram;
  logic                w_wr_led;
  logic                w_wr_count;
  logic                w_wr_status;
  logic                w_tick;
  logic                w_wrap;
  logic [DATA_W-1:0]   w_rd_data;

  assign w_region    = ADDR[ADDR_W-1:ADDR_W-2];
  assign w_ram_idx   = ADDR[c_RAM_AW-1:0];
  assign w_wr_ram    = W && (w_region == 2'b00);
  assign w_wr_led    = W && (w_region == 2'b01);
  assign w_wr_count  = W && (w_region == 2'b11) && !ADDR[0];
  assign w_wr_status = W && (w_region == 2'b11) &&  ADDR[0];

  assign w_tick = (r_pre == c_PRE_MAX);
  // A COUNT write pre-empts the tick, so it can never produce a wrap.
  assign w_wrap = w_tick && (r_count == '1) && !w_wr_count;

  always_comb begin
    w_rd_data = '0;
    case (w_region)
      2'b00:   w_rd_data = r_ram[w_ram_idx];
      2'b01:   w_rd_data = r_led;
      2'b10:   w_rd_data = r_sw_sync;
      default: begin
        if (ADDR[0]) w_rd_data[0] = r_flag;
        else         w_rd_data    = r_count;
      end
    endcase
  end

  // RAM has no reset; the rst gate drops writes that land on a reset edge.
  always_ff @(posedge clk) begin
    if (w_wr_ram && !rst) r_ram[w_ram_idx] <= Dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_din     <= '0;
      r_led     <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_din     <= w_rd_data;
      r_sw_meta <= SW;
      r_sw_sync <= r_sw_meta;
      if (w_wr_led) r_led <= Dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_pre   <= '0;
      r_flag  <= 1'b0;
    end else begin
      if (w_wr_count) begin
        r_count <= Dout;
        r_pre   <= '0;
      end else if (w_tick) begin
        r_count <= r_count + 1'b1;
        r_pre   <= '0;
      end else begin
        r_pre   <= r_pre + 1'b1;
      end
      if (w_wrap)           r_flag <= 1'b1;
      else if (w_wr_status) r_flag <= 1'b0;
    end
  end

  assign Din  = r_din;
  assign LEDR = r_led;

endmodule

`default_nettype wire
